// File: rtl/common_types_pkg.sv
// rtl/common_types_pkg.sv - shared types and constants for the divider
package common_types_pkg;

    localparam int DIV_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam logic [DIV_W-1:0] DIV_BY_ZERO_Q = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0] SIGNED_MIN    = {1'b1, {(DIV_W-1){1'b0}}};

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/response bundle between execute stage and divider
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             div_signed;
    logic             div_rem;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, div_signed, div_rem, dividend, divisor, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, div_signed, div_rem, dividend, divisor, flush,
        output busy, done, result
    );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one radix-2 restoring shift/trial-subtract/restore step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The partial remainder stays below the divisor, so WIDTH+1 bits hold the shift.
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor_i};

    always_comb begin
        if (!diff[WIDTH]) begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle RISC-V M-extension divider for the execute stage
module div_unit
    import common_types_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic      CLK,
    input  logic      nRST,
    div_unit_if.slave dif
);
    localparam int               CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             sel_rem_q, sel_rem_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0] step_rem, step_quo;
    logic             a_neg, b_neg, accept;
    logic [WIDTH-1:0] a_abs, b_abs, fix_q, fix_r;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    assign a_neg  = dif.div_signed & dif.dividend[WIDTH-1];
    assign b_neg  = dif.div_signed & dif.divisor[WIDTH-1];
    assign a_abs  = a_neg ? -dif.dividend : dif.dividend;
    assign b_abs  = b_neg ? -dif.divisor : dif.divisor;
    assign fix_q  = neg_q_q ? -quo_q : quo_q;
    assign fix_r  = neg_r_q ? -rem_q : rem_q;
    assign accept = dif.start && !dif.flush && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        sel_rem_d = sel_rem_q;
        result_d  = result_q;

        case (state_q)
            CALC: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                result_d = sel_rem_q ? fix_r : fix_q;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
        endcase

        // Acceptance from DONE overrides the return to IDLE for back-to-back issue.
        if (accept) begin
            if (dif.divisor == '0) begin
                result_d = dif.div_rem ? dif.dividend : ONES;
                state_d  = DONE;
            end else if (dif.div_signed && dif.dividend == MIN_V && dif.divisor == ONES) begin
                result_d = dif.div_rem ? '0 : MIN_V;
                state_d  = DONE;
            end else begin
                quo_d     = a_abs;
                rem_d     = '0;
                dvsr_d    = b_abs;
                neg_q_d   = a_neg ^ b_neg;
                neg_r_d   = a_neg;
                sel_rem_d = dif.div_rem;
                count_d   = CNT_W'(WIDTH);
                state_d   = CALC;
            end
        end

        if (dif.flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            sel_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            sel_rem_q <= sel_rem_d;
            result_q  <= result_d;
        end
    end

    assign dif.busy   = (state_q == CALC) || (state_q == FIX);
    assign dif.done   = (state_q == DONE);
    assign dif.result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed scoreboard bench for div_unit
module tb_div_unit;
    import common_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];

    div_unit_if #(.WIDTH(32)) dif ();

    div_unit #(.WIDTH(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .dif  (dif)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drives a request onto the bus at the current (negative-edge) time.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic rem, input logic [31:0] expv, input bit push);
        dif.dividend   = a;
        dif.divisor    = b;
        dif.div_signed = sgn;
        dif.div_rem    = rem;
        dif.start      = 1'b1;
        if (push) exp_q.push_back(expv);
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy, input bit poke);
        int n;
        int bcnt;
        logic [31:0] expv;
        @(negedge CLK);
        dif.start = 1'b0;
        n = 1;
        bcnt = 0;
        while (!dif.done && n < 100) begin
            if (dif.busy) bcnt++;
            if (poke && n == 5) issue(32'd1, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0);
            @(negedge CLK);
            dif.start = 1'b0;
            n++;
        end
        chk({tag, " done"}, 32'(dif.done), 32'd1);
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " busy cycles"}, 32'(bcnt), 32'(exp_busy));
        if (dif.done) begin
            chk({tag, " scoreboard nonempty"}, 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                expv = exp_q.pop_front();
                chk({tag, " result"}, dif.result, expv);
            end
        end
    endtask

    task automatic quiet(input string tag, input int cycles, input logic [31:0] exp_res);
        int dn;
        dn = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if (dif.done) dn++;
        end
        chk({tag, " no done"}, 32'(dn), 32'd0);
        chk({tag, " result held"}, dif.result, exp_res);
    endtask

    initial begin
        dif.start = 1'b0;
        dif.div_signed = 1'b0;
        dif.div_rem = 1'b0;
        dif.dividend = '0;
        dif.divisor = '0;
        dif.flush = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset busy", 32'(dif.busy), 32'd0);
        chk("reset done", 32'(dif.done), 32'd0);
        chk("reset result", dif.result, 32'd0);
        nRST = 1'b1;
        @(negedge CLK);

        issue(32'd20, 32'd3, 1'b0, 1'b0, 32'd6, 1'b1);
        wait_done("divu 20/3", 34, 33, 1'b0);
        @(negedge CLK);
        chk("done one cycle", 32'(dif.done), 32'd0);

        issue(-32'sd20, 32'd3, 1'b1, 1'b0, 32'hFFFF_FFFA, 1'b1);
        wait_done("div -20/3", 34, 33, 1'b0);
        @(negedge CLK);
        issue(-32'sd20, 32'd3, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
        wait_done("rem -20/3", 34, 33, 1'b0);
        @(negedge CLK);
        issue(32'd20, -32'sd3, 1'b1, 1'b1, 32'd2, 1'b1);
        wait_done("rem 20/-3", 34, 33, 1'b0);
        @(negedge CLK);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 1'b1);
        wait_done("divu min/ones", 34, 33, 1'b0);
        @(negedge CLK);

        issue(32'd7, 32'd0, 1'b0, 1'b0, DIV_BY_ZERO_Q, 1'b1);
        wait_done("divu 7/0", 1, 0, 1'b0);
        @(negedge CLK);
        issue(32'd7, 32'd0, 1'b1, 1'b1, 32'd7, 1'b1);
        wait_done("rem 7/0", 1, 0, 1'b0);
        @(negedge CLK);
        issue(SIGNED_MIN, 32'hFFFF_FFFF, 1'b1, 1'b0, SIGNED_MIN, 1'b1);
        wait_done("div overflow", 1, 0, 1'b0);
        @(negedge CLK);
        issue(SIGNED_MIN, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 1'b1);
        wait_done("rem overflow", 1, 0, 1'b0);
        @(negedge CLK);

        issue(32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge CLK);
        dif.start = 1'b0;
        repeat (9) @(negedge CLK);
        dif.flush = 1'b1;
        @(negedge CLK);
        dif.flush = 1'b0;
        chk("flush busy", 32'(dif.busy), 32'd0);
        quiet("flush", 40, 32'd0);
        issue(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 1'b1);
        wait_done("divu 100/7", 34, 33, 1'b0);
        @(negedge CLK);

        issue(32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge CLK);
        dif.start = 1'b0;
        repeat (9) @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk("nrst busy", 32'(dif.busy), 32'd0);
        chk("nrst done", 32'(dif.done), 32'd0);
        chk("nrst result", dif.result, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        quiet("nrst", 40, 32'd0);

        issue(32'd20, 32'd3, 1'b0, 1'b0, 32'd6, 1'b1);
        wait_done("b2b first", 34, 33, 1'b0);
        issue(32'd9, 32'd2, 1'b0, 1'b0, 32'd4, 1'b1);
        wait_done("b2b second", 34, 33, 1'b1);
        quiet("ignored start", 40, 32'd4);

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
